// File: rtl/serial_stream_host.sv
// serial_stream_host
//   Host-side endpoint of the bit-serial valid/ready link.
//   TX: parallel words are buffered in a small FIFO and serialized MSB-first.
//   RX: serial bits are collected MSB-first into parallel words for a sink.
//
// Parameters
//   DATA_WIDTH     bits per serial word (TX and RX)
//   TX_FIFO_DEPTH  TX word FIFO entries (power of two, >= 2)
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_en                     global enable; low freezes all state
//   iv_tx_data/i_tx_valid/o_tx_ready           parallel TX input
//   o_ser_dout/o_ser_dout_valid/i_ser_ready    serial TX output
//   i_ser_din/i_ser_din_valid/o_ser_ready      serial RX input
//   ov_rx_data/o_rx_valid/i_rx_ready           parallel RX output
//
// Optional: define SERIAL_HOST_STATS_EN to add saturating word counters
//   ov_tx_words / ov_rx_words.
module serial_stream_host #(
   parameter int unsigned DATA_WIDTH    = 24,
   parameter int unsigned TX_FIFO_DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] iv_tx_data,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic                  o_ser_dout,
   output logic                  o_ser_dout_valid,
   input  logic                  i_ser_ready,
   input  logic                  i_ser_din,
   input  logic                  i_ser_din_valid,
   output logic                  o_ser_ready,
   output logic [DATA_WIDTH-1:0] ov_rx_data,
   output logic                  o_rx_valid,
   input  logic                  i_rx_ready
`ifdef SERIAL_HOST_STATS_EN
   ,
   output logic [15:0]           ov_tx_words,
   output logic [15:0]           ov_rx_words
`endif
);

   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);

   localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
   localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(TX_FIFO_DEPTH);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // TX FIFO
   logic [DATA_WIDTH-1:0] mem_q [TX_FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;

   // TX serializer
   logic [0:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [CW-1:0]         tx_cnt_q, tx_cnt_d;

   // RX deserializer
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;

   logic                  full, empty, push, pop;
   logic                  tx_hs, tx_last, rx_hs, rx_last;
   logic [DATA_WIDTH-1:0] rx_word;

   assign full    = (count_q == FIFO_FULL);
   assign empty   = (count_q == '0);

   assign o_tx_ready       = i_en & ~full;
   assign o_ser_dout_valid = i_en & (state_q == ST_SHIFT);
   assign o_ser_dout       = (state_q == ST_SHIFT) & tx_shift_q[DATA_WIDTH-1];

   assign push    = i_tx_valid & o_tx_ready;
   assign tx_hs   = o_ser_dout_valid & i_ser_ready;
   assign tx_last = tx_hs & (tx_cnt_q == '0);
   // Pop either to start from IDLE or to chain the next word onto the last
   // bit handshake, so consecutive words leave without a bubble.
   assign pop     = i_en & ~empty & ((state_q == ST_IDLE) | tx_last);

   // Ready depends only on registered state: a full output register with a
   // word one bit from completion refuses the last bit until the sink drains.
   assign o_ser_ready = i_en & ~(rx_valid_q & (rx_cnt_q == LAST_BIT));
   assign rx_hs       = i_ser_din_valid & o_ser_ready;
   assign rx_last     = rx_hs & (rx_cnt_q == LAST_BIT);
   assign rx_word     = {rx_shift_q[DATA_WIDTH-2:0], i_ser_din};

   assign ov_rx_data = rx_data_q;
   assign o_rx_valid = rx_valid_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      state_d    = state_q;
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      rx_shift_d = rx_shift_q;
      rx_cnt_d   = rx_cnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase

      if (pop) begin
         state_d    = ST_SHIFT;
         tx_shift_d = mem_q[rd_ptr_q];
         tx_cnt_d   = LAST_BIT;
      end else if (tx_hs) begin
         tx_shift_d = tx_shift_q << 1;
         if (tx_cnt_q == '0) state_d  = ST_IDLE;
         else                tx_cnt_d = tx_cnt_q - CW'(1);
      end

      if (rx_valid_q & i_rx_ready & i_en) rx_valid_d = 1'b0;
      if (rx_hs) begin
         rx_shift_d = rx_word;
         if (rx_cnt_q == LAST_BIT) begin
            rx_cnt_d   = '0;
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
         end else begin
            rx_cnt_d   = rx_cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= iv_tx_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         tx_shift_q <= '0;
         tx_cnt_q   <= '0;
         rx_shift_q <= '0;
         rx_cnt_q   <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else if (i_en) begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         state_q    <= state_d;
         tx_shift_q <= tx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

`ifdef SERIAL_HOST_STATS_EN
   logic [15:0] tx_words_q, rx_words_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_words_q <= '0;
         rx_words_q <= '0;
      end else if (i_en) begin
         if (tx_last && (tx_words_q != '1)) tx_words_q <= tx_words_q + 16'd1;
         if (rx_last && (rx_words_q != '1)) rx_words_q <= rx_words_q + 16'd1;
      end
   end

   assign ov_tx_words = tx_words_q;
   assign ov_rx_words = rx_words_q;
`endif

endmodule
